// File: rtl/bomber_pkg.sv
// Shared constants and types for the bomber video game: screen geometry,
// facing direction, sprite indices and the player-controller state encoding.
package bomber_pkg;

  localparam int HACTIVE     = 800;
  localparam int VACTIVE     = 600;
  localparam int SPRITE_SIZE = 32;

  typedef enum logic [1:0] {
    DOWN  = 2'd0,
    UP    = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic {
    IDLE   = 1'b0,
    MOVING = 1'b1
  } pctrl_state_t;

  localparam logic [2:0] SPR_STAND_DOWN  = 3'd0;
  localparam logic [2:0] SPR_STAND_UP    = 3'd1;
  localparam logic [2:0] SPR_STAND_LEFT  = 3'd2;
  localparam logic [2:0] SPR_STAND_RIGHT = 3'd3;
  localparam logic [2:0] SPR_STEP_VERT   = 3'd4;
  localparam logic [2:0] SPR_STEP_LEFT   = 3'd5;
  localparam logic [2:0] SPR_STEP_RIGHT  = 3'd6;

  // Up and down share one step sprite, so index 7 is never produced.
  function automatic logic [2:0] sprite_of(input dir_t d, input logic step);
    logic [2:0] s;
    case (d)
      UP:      s = step ? SPR_STEP_VERT  : SPR_STAND_UP;
      LEFT:    s = step ? SPR_STEP_LEFT  : SPR_STAND_LEFT;
      RIGHT:   s = step ? SPR_STEP_RIGHT : SPR_STAND_RIGHT;
      default: s = step ? SPR_STEP_VERT  : SPR_STAND_DOWN;
    endcase
    return s;
  endfunction

  // One extra bit of headroom so a step past either edge clamps instead of wrapping.
  function automatic logic signed [10:0] step_clamp(
    input logic signed [10:0] pos,
    input logic signed [11:0] delta,
    input logic signed [11:0] lo,
    input logic signed [11:0] hi
  );
    logic signed [11:0] n;
    n = {pos[10], pos} + delta;
    if (n < lo)      n = lo;
    else if (n > hi) n = hi;
    return n[10:0];
  endfunction

endpackage

// File: rtl/player1_ctrl_btn_sync.sv
// Two-flop synchronizer for a vector of independent asynchronous inputs.
module btn_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/player1_ctrl.sv
// Player-1 position, facing and walk-animation generator. All outputs update
// only on frame_tick so the sprite renderer never sees a mid-frame change.
module player1_ctrl
  import bomber_pkg::*;
#(
  parameter int STEP     = 2,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = HACTIVE - SPRITE_SIZE,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = VACTIVE - SPRITE_SIZE,
  parameter int X_INIT   = 0,
  parameter int Y_INIT   = 0,
  parameter int ANIM_DIV = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                frame_tick,
  input  logic                btn_up,
  input  logic                btn_down,
  input  logic                btn_left,
  input  logic                btn_right,
  input  logic                freeze,
  output logic signed [10:0]  centerX1,
  output logic signed [10:0]  centerY1,
  output logic [2:0]          sprite_num,
  output logic                moving,
  output pctrl_state_t        o_state
);

  localparam logic signed [11:0] L_STEP  = 12'(STEP);
  localparam logic signed [11:0] L_X_MIN = 12'(X_MIN);
  localparam logic signed [11:0] L_X_MAX = 12'(X_MAX);
  localparam logic signed [11:0] L_Y_MIN = 12'(Y_MIN);
  localparam logic signed [11:0] L_Y_MAX = 12'(Y_MAX);
  localparam logic [7:0]         L_ANIM_LAST = 8'(ANIM_DIV - 1);

  logic [3:0]         w_btn;
  logic               w_up, w_down, w_left, w_right;
  logic               w_req;
  dir_t               w_req_dir;
  logic signed [11:0] w_dx, w_dy;
  logic signed [10:0] w_new_x, w_new_y;
  logic               w_moved;
  logic               w_anim_wrap;
  logic               w_phase_nxt;

  pctrl_state_t       r_state;
  dir_t               r_dir;
  logic               r_phase;
  logic [7:0]         r_anim_cnt;

  btn_sync #(.WIDTH(4)) u_btn_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async ({btn_up, btn_down, btn_left, btn_right}),
    .o_sync  (w_btn)
  );

  // Opposite buttons cancel before priority is applied.
  assign w_up    = w_btn[3] & ~w_btn[2];
  assign w_down  = w_btn[2] & ~w_btn[3];
  assign w_left  = w_btn[1] & ~w_btn[0];
  assign w_right = w_btn[0] & ~w_btn[1];

  always_comb begin
    w_req     = 1'b1;
    w_req_dir = DOWN;
    if (w_up)         w_req_dir = UP;
    else if (w_down)  w_req_dir = DOWN;
    else if (w_left)  w_req_dir = LEFT;
    else if (w_right) w_req_dir = RIGHT;
    else              w_req     = 1'b0;
  end

  always_comb begin
    w_dx = '0;
    w_dy = '0;
    case (w_req_dir)
      UP:      w_dy = -L_STEP;
      DOWN:    w_dy = L_STEP;
      LEFT:    w_dx = -L_STEP;
      default: w_dx = L_STEP;
    endcase
  end

  assign w_new_x     = step_clamp(centerX1, w_dx, L_X_MIN, L_X_MAX);
  assign w_new_y     = step_clamp(centerY1, w_dy, L_Y_MIN, L_Y_MAX);
  assign w_moved     = (w_new_x != centerX1) || (w_new_y != centerY1);
  assign w_anim_wrap = (r_anim_cnt == L_ANIM_LAST);
  assign w_phase_nxt = r_phase ^ w_anim_wrap;

  // IDLE and MOVING share transitions: a live request moves, otherwise IDLE.
  // Freeze keeps the animation phase so walking resumes where it stopped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_dir      <= DOWN;
      r_phase    <= 1'b0;
      r_anim_cnt <= '0;
      centerX1   <= 11'(X_INIT);
      centerY1   <= 11'(Y_INIT);
      sprite_num <= SPR_STAND_DOWN;
      moving     <= 1'b0;
    end else if (frame_tick) begin
      if (w_req && !freeze) begin
        r_state    <= MOVING;
        r_dir      <= w_req_dir;
        centerX1   <= w_new_x;
        centerY1   <= w_new_y;
        moving     <= w_moved;
        r_anim_cnt <= w_anim_wrap ? '0 : r_anim_cnt + 8'd1;
        r_phase    <= w_phase_nxt;
        sprite_num <= sprite_of(w_req_dir, w_phase_nxt);
      end else begin
        r_state    <= IDLE;
        moving     <= 1'b0;
        sprite_num <= sprite_of(r_dir, 1'b0);
        if (!w_req) begin
          r_phase    <= 1'b0;
          r_anim_cnt <= '0;
        end
      end
    end
  end

  assign o_state = r_state;

endmodule

// File: tb/tb_player1_ctrl.sv
// Directed bench for player1_ctrl: main instance plus two instances parked
// next to the arena edges for the clamp cases.
module tb_player1_ctrl;
  import bomber_pkg::*;

  localparam int W = 27;

  logic       clk        = 1'b0;
  logic       clk_en     = 1'b0;
  logic       reset_n    = 1'b1;
  logic       frame_tick = 1'b0;
  logic       freeze     = 1'b0;
  logic       btn_up     = 1'b0;
  logic       btn_down   = 1'b0;
  logic       btn_left   = 1'b0;
  logic       btn_right  = 1'b0;
  logic [3:0] b_btn      = '0;
  logic [3:0] c_btn      = '0;

  logic signed [10:0] a_x, a_y, b_x, b_y, c_x, c_y;
  logic [2:0]         a_spr, b_spr, c_spr;
  logic               a_mv, b_mv, c_mv;
  pctrl_state_t       a_st, b_st, c_st;

  logic [W-1:0] obs_a, obs_b, obs_c;
  logic [W-1:0] exp_q[$];
  int           n_tests = 0;
  int           n_fails = 0;

  assign obs_a = {a_x, a_y, a_spr, a_mv, a_st};
  assign obs_b = {b_x, b_y, b_spr, b_mv, b_st};
  assign obs_c = {c_x, c_y, c_spr, c_mv, c_st};

  player1_ctrl #(.X_INIT(100), .Y_INIT(200)) dut_a (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .freeze(freeze), .centerX1(a_x), .centerY1(a_y), .sprite_num(a_spr),
    .moving(a_mv), .o_state(a_st)
  );

  player1_ctrl #(.X_INIT(767), .Y_INIT(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
    .btn_up(b_btn[3]), .btn_down(b_btn[2]), .btn_left(b_btn[1]), .btn_right(b_btn[0]),
    .freeze(freeze), .centerX1(b_x), .centerY1(b_y), .sprite_num(b_spr),
    .moving(b_mv), .o_state(b_st)
  );

  player1_ctrl #(.X_INIT(1), .Y_INIT(0)) dut_c (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
    .btn_up(c_btn[3]), .btn_down(c_btn[2]), .btn_left(c_btn[1]), .btn_right(c_btn[0]),
    .freeze(freeze), .centerX1(c_x), .centerY1(c_y), .sprite_num(c_spr),
    .moving(c_mv), .o_state(c_st)
  );

  // clock / reset
  initial begin
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic set_main(input logic [3:0] b);
    @(negedge clk);
    {btn_up, btn_down, btn_left, btn_right} = b;
    repeat (3) @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  // scoreboard
  task automatic expect_out(input int x, input int y, input int s, input int m,
                            input pctrl_state_t st);
    exp_q.push_back({11'(x), 11'(y), 3'(s), 1'(m), st});
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] obs);
    logic [W-1:0] exp_w;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fails++;
      $error("FAIL %s: no expected entry queued", tag);
      return;
    end
    exp_w = exp_q.pop_front();
    assert (obs === exp_w) else begin
      n_fails++;
      $error("FAIL %s: got x=%0d y=%0d spr=%0d mv=%0b st=%0b, want x=%0d y=%0d spr=%0d mv=%0b st=%0b",
             tag, $signed(obs[26:16]), $signed(obs[15:5]), obs[4:2], obs[1], obs[0],
             $signed(exp_w[26:16]), $signed(exp_w[15:5]), exp_w[4:2], exp_w[1], exp_w[0]);
    end
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #2;
    expect_out(100, 200, 0, 0, IDLE); check_out("reset_a", obs_a);
    expect_out(767, 0, 0, 0, IDLE);   check_out("reset_b", obs_b);
    expect_out(1, 0, 0, 0, IDLE);     check_out("reset_c", obs_c);

    clk_en = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    expect_out(100, 200, 0, 0, IDLE); check_out("post_reset_idle", obs_a);

    set_main(4'b0001);
    for (int i = 1; i <= 8; i++) begin
      expect_out(100 + 2 * i, 200, (i == 8) ? 6 : 3, 1, MOVING);
      tick();
      check_out($sformatf("right_tick%0d", i), obs_a);
    end

    set_main(4'b0000);
    expect_out(116, 200, 3, 0, IDLE);   tick(); check_out("release_idle", obs_a);
    set_main(4'b1110);
    expect_out(114, 200, 2, 1, MOVING); tick(); check_out("ud_cancel_left", obs_a);
    set_main(4'b1111);
    expect_out(114, 200, 2, 0, IDLE);   tick(); check_out("all4_idle", obs_a);
    set_main(4'b1010);
    expect_out(114, 198, 1, 1, MOVING); tick(); check_out("up_over_left", obs_a);
    set_main(4'b0101);
    expect_out(114, 200, 0, 1, MOVING); tick(); check_out("down_over_right", obs_a);

    @(negedge clk) freeze = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_out(114, 200, 0, 0, IDLE);
      tick();
      check_out($sformatf("freeze_tick%0d", i), obs_a);
    end

    expect_out(114, 200, 0, 0, IDLE);
    repeat (10) begin
      @(negedge clk);
      {btn_up, btn_down, btn_left, btn_right} = 4'($urandom_range(0, 15));
      freeze = 1'($urandom_range(0, 1));
    end
    check_out("no_tick_stable", obs_a);

    @(negedge clk) freeze = 1'b0;
    set_main(4'b0100);
    expect_out(114, 202, 0, 1, MOVING); tick(); check_out("resume_down", obs_a);

    expect_out(114, 204, 0, 1, MOVING);
    expect_out(114, 206, 0, 1, MOVING);
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk);
    check_out("b2b_first", obs_a);
    @(negedge clk) frame_tick = 1'b0;
    check_out("b2b_second", obs_a);

    #2 reset_n = 1'b0;
    #1;
    expect_out(100, 200, 0, 0, IDLE); check_out("async_reset", obs_a);
    {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
    @(negedge clk) reset_n = 1'b1;

    b_btn = 4'b0001;
    c_btn = 4'b0010;
    repeat (3) @(negedge clk);
    expect_out(768, 0, 3, 1, MOVING);
    expect_out(0, 0, 2, 1, MOVING);
    expect_out(100, 200, 0, 0, IDLE);
    tick();
    check_out("xmax_clamp", obs_b);
    check_out("xmin_clamp", obs_c);
    check_out("idle_no_req", obs_a);

    expect_out(768, 0, 3, 0, MOVING);
    expect_out(0, 0, 2, 0, MOVING);
    tick();
    check_out("xmax_hold", obs_b);
    check_out("xmin_hold", obs_c);

    c_btn = 4'b1000;
    repeat (3) @(negedge clk);
    expect_out(0, 0, 1, 0, MOVING);
    tick();
    check_out("ymin_hold", obs_c);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule

// File: doc/player1_ctrl.md
Name: player1_ctrl

Overview:
Generates the position (centerX1, centerY1) and sprite index (sprite_num) consumed by the player-1 sprite renderer. It is the producer end of that interface.
- Samples four direction buttons once per video frame.
- Moves the player by a fixed step inside the arena and clamps at the arena edges.
- Sequences walk-animation frames.
- All outputs change only on the frame tick, so the renderer never sees a position change mid-frame.

Parameters:
STEP, 2, pixels moved per frame while a direction is held (1..8)
X_MIN, 0, leftmost allowed centerX1 (top-left corner of the 32x32 sprite)
X_MAX, 768, rightmost allowed centerX1 (HACTIVE-32)
Y_MIN, 0, topmost allowed centerY1
Y_MAX, 568, bottommost allowed centerY1 (VACTIVE-32)
X_INIT, 0, centerX1 after reset
Y_INIT, 0, centerY1 after reset
ANIM_DIV, 8, frames per animation phase toggle (1..255)

Ports:
clk  in  1  pixel clock
reset_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse per frame, issued at start of vertical blanking
btn_up  in  1  raw button, active-high, asynchronous to clk
btn_down  in  1  raw button
btn_left  in  1  raw button
btn_right  in  1  raw button
freeze  in  1  synchronous, active-high; when 1, movement and animation hold
centerX1  out  11 signed  sprite left X
centerY1  out  11 signed  sprite top Y
sprite_num  out  3  sprite index 0..6, never 7
moving  out  1  1 while the player moved on the last frame tick

Behaviour:
- Reset (async, reset_n=0) values:
  - centerX1=X_INIT, centerY1=Y_INIT
  - sprite_num=0, moving=0, dir=DOWN, phase=0, anim counter=0
  - synchronizer flops=0
- Buttons pass through 2-flop synchronizers. A button change becomes visible to the frame logic 2 clk later.
- Direction resolution from synchronized buttons:
  - Opposite pairs cancel: up&down yields no vertical request; left&right yields no horizontal request.
  - Of the remaining requests, priority is up > down > left > right. One direction at most; no diagonals.
- State machine, 2 states, evaluated only on cycles with frame_tick=1:
  - IDLE:
    - request present and freeze=0 -> MOVING; dir=request; apply one step this tick.
    - otherwise stay IDLE.
  - MOVING:
    - request present and freeze=0 -> stay MOVING; dir=request (direction may change without passing through IDLE); apply one step.
    - no request -> IDLE; phase=0; anim counter=0.
    - freeze=1 -> IDLE; position is held.
- Step arithmetic:
  - Computed in 12-bit signed: next = pos ± STEP.
  - If next < MIN, next = MIN; if next > MAX, next = MAX. Clamp, never wrap.
  - At the limit the state stays MOVING but the position is unchanged, and moving=0 for that tick.
- moving is registered on frame_tick: 1 iff the position actually changed on that tick.
- Animation:
  - While MOVING, anim counter increments each frame_tick.
  - When the counter reaches ANIM_DIV-1 it resets to 0 and phase toggles.
- sprite_num mapping:
  - Stand sprites: 0 down, 1 up, 2 left, 3 right.
  - Step sprites: 4 vertical (up/down), 5 left, 6 right.
  - IDLE or phase=0: stand sprite of dir. MOVING with phase=1: step sprite of dir.
- Latency: outputs are registered and valid the clk after the frame_tick cycle. Between ticks they are held constant.
- Two consecutive-cycle frame_tick pulses are legal, each processed independently.
- reset_n asserted mid-frame forces reset values immediately. Release is synchronous to clk at the design level.
- freeze alone (no frame_tick) does not change outputs.

Decomposition:
- Shared package bomber_pkg holds:
  - HACTIVE=800, VACTIVE=600, SPRITE_SIZE=32
  - dir_t enum {DOWN, UP, LEFT, RIGHT}
  - sprite index constants SPR_STAND_DOWN..SPR_STEP_RIGHT
  - state enum pctrl_state_t {IDLE, MOVING}
- One sub-module, btn_sync: parameterised-width 2-flop synchronizer, reset by reset_n, used for the 4 buttons as a 4-bit vector.

Test Plan:
- Reset with X_INIT=100, Y_INIT=200 -> centerX1=100, centerY1=200, sprite_num=0, moving=0 with no clock running.
- Hold btn_right, 3 frame_ticks, STEP=2 -> centerX1 100->102->104->106, moving=1, sprite_num=3 (phase 0, ANIM_DIV=8).
- Hold btn_right 8 ticks -> sprite_num=6 after 8th tick; release, next tick -> sprite_num=3, state IDLE, moving=0.
- Start centerX1=767, hold btn_right -> 768 on first tick, then held at 768 with moving=0; repeat at X_MIN with btn_left from 1 -> 0.
- btn_up&btn_down&btn_left held -> only left move, sprite_num=2; all four held -> no move, IDLE.
- freeze=1 while holding btn_down across 4 ticks -> position unchanged, state IDLE; buttons toggled between ticks -> outputs stable; reset_n pulsed mid-move -> immediate return to X_INIT/Y_INIT, sprite_num=0.
